// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble
// insertion and stall/flush handling in front of the execute-stage ALU.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_wr_addr,
    input  logic [5:0]  id_alufun,
    input  logic        id_sign,
    input  logic        id_alusrc1,
    input  logic        id_alusrc2,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_wr_addr,
    input  logic [31:0] mem_result,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_wr_addr,
    input  logic [31:0] wb_data,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_dataa,
    output logic [31:0] ex_datab,
    output logic [5:0]  ex_alufun,
    output logic        ex_sign,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_wr_addr,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        load_use_hazard
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  wr_addr;
        logic [5:0]  alufun;
        logic        sign;
        logic        alusrc1;
        logic        alusrc2;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
    } stage_t;

    stage_t      stage_q, stage_d;
    logic [31:0] fwd_rs, fwd_rt;
    logic [31:0] cap_rs, cap_rt;

    // MEM outranks WB; register 0 is hard-wired and never forwarded.
    always_comb begin
        fwd_rs = stage_q.rs_data;
        if (mem_regwrite && mem_wr_addr == stage_q.rs_addr && stage_q.rs_addr != 5'd0)
            fwd_rs = mem_result;
        else if (wb_regwrite && wb_wr_addr == stage_q.rs_addr && stage_q.rs_addr != 5'd0)
            fwd_rs = wb_data;

        fwd_rt = stage_q.rt_data;
        if (mem_regwrite && mem_wr_addr == stage_q.rt_addr && stage_q.rt_addr != 5'd0)
            fwd_rt = mem_result;
        else if (wb_regwrite && wb_wr_addr == stage_q.rt_addr && stage_q.rt_addr != 5'd0)
            fwd_rt = wb_data;
    end

    // The register file is written at the end of WB, so ID may have read stale data.
    assign cap_rs = (wb_regwrite && wb_wr_addr == id_rs_addr && id_rs_addr != 5'd0)
                    ? wb_data : id_rs_data;
    assign cap_rt = (wb_regwrite && wb_wr_addr == id_rt_addr && id_rt_addr != 5'd0)
                    ? wb_data : id_rt_data;

    assign load_use_hazard = stage_q.valid && stage_q.memread && stage_q.wr_addr != 5'd0 &&
                             id_valid && (stage_q.wr_addr == id_rs_addr ||
                                          stage_q.wr_addr == id_rt_addr);

    // NOTE: every path starts from a full default so no field can infer a latch.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (stall) begin
            // Absorb values leaving MEM/WB while held, or they would be lost.
            stage_d.rs_data = fwd_rs;
            stage_d.rt_data = fwd_rt;
        end else if (load_use_hazard || !id_valid) begin
            stage_d = '0;
        end else begin
            stage_d.valid    = 1'b1;
            stage_d.pc       = id_pc;
            stage_d.rs_data  = cap_rs;
            stage_d.rt_data  = cap_rt;
            stage_d.rs_addr  = id_rs_addr;
            stage_d.rt_addr  = id_rt_addr;
            stage_d.imm      = id_imm;
            stage_d.shamt    = id_shamt;
            stage_d.wr_addr  = id_wr_addr;
            stage_d.alufun   = id_alufun;
            stage_d.sign     = id_sign;
            stage_d.alusrc1  = id_alusrc1;
            stage_d.alusrc2  = id_alusrc2;
            stage_d.regwrite = id_regwrite;
            stage_d.memread  = id_memread;
            stage_d.memwrite = id_memwrite;
        end
    end

    // NOTE: sequential state uses non-blocking assignment; reset clears it asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stage_q <= '0;
        else        stage_q <= stage_d;
    end

    assign ex_valid      = stage_q.valid;
    assign ex_pc         = stage_q.pc;
    assign ex_dataa      = stage_q.alusrc1 ? {27'b0, stage_q.shamt} : fwd_rs;
    assign ex_datab      = stage_q.alusrc2 ? stage_q.imm : fwd_rt;
    assign ex_alufun     = stage_q.alufun;
    assign ex_sign       = stage_q.sign;
    assign ex_store_data = fwd_rt;
    assign ex_wr_addr    = stage_q.wr_addr;
    assign ex_regwrite   = stage_q.regwrite;
    assign ex_memread    = stage_q.memread;
    assign ex_memwrite   = stage_q.memwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an instruction-level model checked on every
// falling edge, plus hand-computed expectations at the interesting points.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_wr_addr;
    logic [5:0]  id_alufun;
    logic        id_sign, id_alusrc1, id_alusrc2, id_regwrite, id_memread, id_memwrite;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_wr_addr, wb_wr_addr;
    logic [31:0] mem_result, wb_data;
    logic        stall, flush;
    logic        ex_valid, ex_sign, ex_regwrite, ex_memread, ex_memwrite, load_use_hazard;
    logic [31:0] ex_pc, ex_dataa, ex_datab, ex_store_data;
    logic [5:0]  ex_alufun;
    logic [4:0]  ex_wr_addr;

    int n_total = 0;
    int n_pass  = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_wr_addr(id_wr_addr),
        .id_alufun(id_alufun), .id_sign(id_sign),
        .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .mem_regwrite(mem_regwrite), .mem_wr_addr(mem_wr_addr), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_wr_addr(wb_wr_addr), .wb_data(wb_data),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_dataa(ex_dataa), .ex_datab(ex_datab),
        .ex_alufun(ex_alufun), .ex_sign(ex_sign),
        .ex_store_data(ex_store_data), .ex_wr_addr(ex_wr_addr),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Instruction currently in EX, as the model sees it (a bubble has valid=0, all fields 0).
    typedef struct {
        logic        valid;
        logic [31:0] pc, rs_val, rt_val, imm;
        logic [4:0]  rs, rt, shamt, dst;
        logic [5:0]  fun;
        logic        sign, use_shamt, use_imm, rw, mr, mw;
    } instr_t;

    instr_t ex_m;

    function automatic instr_t bubble();
        instr_t b;
        b = '{valid: 1'b0, pc: 32'd0, rs_val: 32'd0, rt_val: 32'd0, imm: 32'd0,
              rs: 5'd0, rt: 5'd0, shamt: 5'd0, dst: 5'd0, fun: 6'd0,
              sign: 1'b0, use_shamt: 1'b0, use_imm: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0};
        return b;
    endfunction

    // Newest value of register r given what EX holds and what MEM/WB are writing now.
    function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] held);
        if (r == 5'd0) return held;
        if (mem_regwrite && mem_wr_addr == r) return mem_result;
        if (wb_regwrite && wb_wr_addr == r) return wb_data;
        return held;
    endfunction

    function automatic logic model_hazard();
        return ex_m.valid && ex_m.mr && ex_m.dst != 5'd0 && id_valid &&
               (ex_m.dst == id_rs_addr || ex_m.dst == id_rt_addr);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_m = bubble();
        end else if (flush) begin
            ex_m = bubble();
        end else if (stall) begin
            ex_m.rs_val = newest(ex_m.rs, ex_m.rs_val);
            ex_m.rt_val = newest(ex_m.rt, ex_m.rt_val);
        end else if (model_hazard() || !id_valid) begin
            ex_m = bubble();
        end else begin
            ex_m.valid = 1'b1;       ex_m.pc = id_pc;
            ex_m.rs = id_rs_addr;    ex_m.rt = id_rt_addr;
            ex_m.rs_val = (wb_regwrite && wb_wr_addr == id_rs_addr && id_rs_addr != 0) ? wb_data : id_rs_data;
            ex_m.rt_val = (wb_regwrite && wb_wr_addr == id_rt_addr && id_rt_addr != 0) ? wb_data : id_rt_data;
            ex_m.imm = id_imm;       ex_m.shamt = id_shamt;   ex_m.dst = id_wr_addr;
            ex_m.fun = id_alufun;    ex_m.sign = id_sign;
            ex_m.use_shamt = id_alusrc1; ex_m.use_imm = id_alusrc2;
            ex_m.rw = id_regwrite;   ex_m.mr = id_memread;    ex_m.mw = id_memwrite;
        end
    end

    always @(negedge clk) begin
        logic [31:0] rs_now, rt_now;
        rs_now = newest(ex_m.rs, ex_m.rs_val);
        rt_now = newest(ex_m.rt, ex_m.rt_val);
        check("m_valid", ex_valid, ex_m.valid);
        check("m_pc", ex_pc, ex_m.pc);
        check("m_dataa", ex_dataa, ex_m.use_shamt ? {27'd0, ex_m.shamt} : rs_now);
        check("m_datab", ex_datab, ex_m.use_imm ? ex_m.imm : rt_now);
        check("m_store", ex_store_data, rt_now);
        check("m_alufun", ex_alufun, ex_m.fun);
        check("m_sign", ex_sign, ex_m.sign);
        check("m_wr_addr", ex_wr_addr, ex_m.dst);
        check("m_ctrl", {ex_regwrite, ex_memread, ex_memwrite}, {ex_m.rw, ex_m.mr, ex_m.mw});
        check("m_hazard", load_use_hazard, model_hazard());
    end

    task automatic clear_id();
        id_valid = 0; id_pc = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_shamt = 0; id_wr_addr = 0; id_alufun = 0;
        id_sign = 0; id_alusrc1 = 0; id_alusrc2 = 0;
        id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    endtask

    task automatic clear_fwd();
        mem_regwrite = 0; mem_wr_addr = 0; mem_result = 0;
        wb_regwrite = 0; wb_wr_addr = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_lw_to_8();
        clear_id();
        id_valid = 1; id_pc = 32'h40; id_rs_addr = 5'd29; id_rs_data = 32'h1000;
        id_alusrc2 = 1; id_imm = 32'd4; id_wr_addr = 5'd8;
        id_regwrite = 1; id_memread = 1; id_alufun = 6'h20;
    endtask

    task automatic load_use_of_8();
        clear_id();
        id_valid = 1; id_pc = 32'h44; id_rs_addr = 5'd8; id_rs_data = 32'hDEAD;
        id_wr_addr = 5'd9; id_regwrite = 1; id_alufun = 6'h20;
    endtask

    initial begin
        reset = 0; stall = 0; flush = 0;
        clear_id(); clear_fwd();
        #2;
        check("rst_valid", ex_valid, 0);
        check("rst_dataa", ex_dataa, 0);
        check("rst_datab", ex_datab, 0);
        check("rst_hazard", load_use_hazard, 0);
        @(negedge clk); @(negedge clk);
        reset = 1;

        // First capture after reset
        id_valid = 1; id_pc = 32'h100; id_rs_addr = 5'd1; id_rs_data = 32'd5;
        id_rt_addr = 5'd2; id_rt_data = 32'd7; id_wr_addr = 5'd9; id_regwrite = 1;
        tick();
        check("first_valid", ex_valid, 1);
        check("first_dataa", ex_dataa, 32'd5);
        check("first_datab", ex_datab, 32'd7);

        // Forwarding priority
        clear_id();
        id_valid = 1; id_rs_addr = 5'd3; id_rs_data = 32'hAA;
        tick();
        mem_regwrite = 1; mem_wr_addr = 5'd3; mem_result = 32'h11;
        wb_regwrite = 1; wb_wr_addr = 5'd3; wb_data = 32'h22;
        #1 check("fwd_mem", ex_dataa, 32'h11);
        mem_regwrite = 0;
        #1 check("fwd_wb", ex_dataa, 32'h22);
        mem_regwrite = 1; mem_wr_addr = 5'd0; wb_wr_addr = 5'd0;
        clear_id();
        id_valid = 1; id_rs_addr = 5'd0; id_rs_data = 32'h77;
        tick();
        check("fwd_r0", ex_dataa, 32'h77);
        clear_fwd();

        // Load-use bubble then WB write-through on capture
        load_lw_to_8();
        tick();
        load_use_of_8();
        #1 check("lu_hazard", load_use_hazard, 1);
        tick();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_memread", ex_memread, 0);
        wb_regwrite = 1; wb_wr_addr = 5'd8; wb_data = 32'h1234;
        tick();
        clear_fwd();
        #1 check("lu_capture", ex_dataa, 32'h1234);

        // Stall absorbs a MEM result that then leaves
        clear_id();
        id_valid = 1; id_pc = 32'h200; id_rt_addr = 5'd4; id_rt_data = 32'd9;
        id_wr_addr = 5'd10; id_regwrite = 1;
        tick();
        mem_regwrite = 1; mem_wr_addr = 5'd4; mem_result = 32'h55;
        stall = 1; id_pc = 32'h300; id_rt_data = 32'h99;
        #1 check("stall_fwd", ex_datab, 32'h55);
        tick();
        mem_regwrite = 0;
        #1 check("stall_absorb", ex_datab, 32'h55);
        check("stall_pc", ex_pc, 32'h200);
        check("stall_wr", ex_wr_addr, 10);
        stall = 0;

        // Stall together with load-use: the load stays in EX
        load_lw_to_8();
        tick();
        load_use_of_8();
        stall = 1;
        #1 check("sh_hazard", load_use_hazard, 1);
        tick();
        check("sh_valid", ex_valid, 1);
        check("sh_memread", ex_memread, 1);
        check("sh_wr", ex_wr_addr, 8);
        stall = 0;
        tick();
        check("sh_bubble", ex_valid, 0);

        // Flush wins over stall
        clear_id();
        id_valid = 1; id_rs_addr = 5'd1; id_rs_data = 32'h33;
        id_regwrite = 1; id_memwrite = 1; id_wr_addr = 5'd2;
        tick();
        flush = 1; stall = 1;
        tick();
        check("flush_valid", ex_valid, 0);
        check("flush_ctrl", {ex_regwrite, ex_memread, ex_memwrite}, 0);
        check("flush_dataa", ex_dataa, 0);
        flush = 0; stall = 0;

        // Shift-amount and immediate operand select
        clear_id();
        id_valid = 1; id_alusrc1 = 1; id_shamt = 5'd31; id_alusrc2 = 1; id_imm = 32'hFFFF8000;
        id_rt_addr = 5'd5; id_rt_data = 32'hCAFE; id_memwrite = 1; id_alufun = 6'h03; id_sign = 1;
        tick();
        check("sel_dataa", ex_dataa, 32'h1F);
        check("sel_datab", ex_datab, 32'hFFFF8000);
        check("sel_store", ex_store_data, 32'hCAFE);
        mem_regwrite = 1; mem_wr_addr = 5'd5; mem_result = 32'hBEEF;
        #1 check("sel_store_fwd", ex_store_data, 32'hBEEF);
        check("sel_datab_imm", ex_datab, 32'hFFFF8000);
        clear_fwd();

        // Invalid ID instruction becomes a bubble
        clear_id();
        id_valid = 0; id_regwrite = 1; id_rs_data = 32'h66; id_wr_addr = 5'd7;
        tick();
        check("inv_valid", ex_valid, 0);
        check("inv_regwrite", ex_regwrite, 0);

        // Reset while stalled clears everything
        clear_id();
        id_valid = 1; id_rs_addr = 5'd1; id_rs_data = 32'h44; id_regwrite = 1; id_wr_addr = 5'd3;
        tick();
        stall = 1;
        #2 reset = 0;
        #1 check("rst_mid_valid", ex_valid, 0);
        check("rst_mid_dataa", ex_dataa, 0);
        check("rst_mid_wr", ex_wr_addr, 0);
        tick();
        reset = 1; stall = 0;
        tick();
        check("rst_recover", ex_dataa, 32'h44);

        clear_id();
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage pipelined CPU, sitting directly upstream of the execute-stage ALU. It registers the decoded instruction and applies MEM/WB operand forwarding to produce the ALU's `DataA`, `DataB`, `ALUFun` and `Sign` inputs, plus the store data and control bits passed downstream. It also:
- detects load-use hazards and inserts bubbles;
- honours global stall and flush requests.

## Interface
Parameters:
- none (datapath fixed at 32 bits, register addresses 5 bits)

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_pc` in 32: PC of ID instruction.
- `id_rs_data`, `id_rt_data` in 32: register-file read data.
- `id_rs_addr`, `id_rt_addr` in 5: source register numbers.
- `id_imm` in 32: already-extended immediate.
- `id_shamt` in 5: shift amount field.
- `id_wr_addr` in 5: destination register.
- `id_alufun` in 6: ALU function code.
- `id_sign` in 1: signed compare/overflow select.
- `id_alusrc1` in 1: 1 selects `{27'b0,shamt}` for DataA.
- `id_alusrc2` in 1: 1 selects `imm` for DataB.
- `id_regwrite`, `id_memread`, `id_memwrite` in 1: control bits.
- `mem_regwrite` in 1, `mem_wr_addr` in 5, `mem_result` in 32: MEM-stage forwarding source.
- `wb_regwrite` in 1, `wb_wr_addr` in 5, `wb_data` in 32: WB-stage forwarding source.
- `stall` in 1: hold this stage (MEM/WB keep advancing).
- `flush` in 1: replace this stage's contents with a bubble.
- `ex_valid` out 1: EX holds a real instruction.
- `ex_pc` out 32: registered PC.
- `ex_dataa`, `ex_datab` out 32: ALU operands.
- `ex_alufun` out 6, `ex_sign` out 1: ALU controls.
- `ex_store_data` out 32: forwarded rt for stores.
- `ex_wr_addr` out 5: registered destination register.
- `ex_regwrite`, `ex_memread`, `ex_memwrite` out 1: registered control bits.
- `load_use_hazard` out 1: combinational; ID must stall one cycle.

## Operation
- **State registers:**
  - valid, pc, rs/rt data and addresses, imm, shamt, wr_addr, alufun, sign, alusrc1/2, regwrite, memread, memwrite.
- **Forwarding (combinational, on registered rs/rt):**
  - `fwd_x` = `mem_result` if `mem_regwrite` and `mem_wr_addr == x_addr` and `x_addr != 0`.
  - Otherwise `wb_data` if the same test passes for WB.
  - Otherwise the registered data.
  - MEM has priority over WB. Register 0 is never forwarded.
- **Operand selection:**
  - `ex_dataa` = alusrc1 ? `{27'b0,shamt}` : `fwd_rs`.
  - `ex_datab` = alusrc2 ? `imm` : `fwd_rt`.
  - `ex_store_data` = `fwd_rt`.
- **Load-use hazard:**
  - `load_use_hazard` = `ex_valid & ex_memread & ex_wr_addr != 0 & id_valid & (ex_wr_addr == id_rs_addr | ex_wr_addr == id_rt_addr)`.
- **Register update, per rising edge, in priority order:**
  1. `flush`: load a bubble (valid=0, regwrite/memread/memwrite=0, alufun=0, all data fields 0).
  2. `stall`: hold every field, except rs/rt data, which load `fwd_rs`/`fwd_rt` so results leaving MEM/WB are not lost.
  3. `load_use_hazard`: load a bubble.
  4. Otherwise: load from ID with WB write-through on capture. Captured rs data = `wb_data` if `wb_regwrite & wb_wr_addr == id_rs_addr & id_rs_addr != 0`, else `id_rs_data`. Same rule for rt.
- **Invalid ID instruction:** `id_valid = 0` loads a bubble on a normal load.

## Timing
- **Reset:** while `reset` is low, all registers are 0 immediately (async). Consequences:
  - all outputs 0, including `ex_valid`, `ex_dataa` and `ex_datab`;
  - `load_use_hazard = 0`.
- **Latency:** one cycle. ID values sampled at edge N appear on `ex_*` after edge N.
- **Forwarded outputs** follow `mem_*`/`wb_*` within the same cycle; there is no registered forwarding delay.
- **Bubbles:** a load-use bubble lasts exactly one cycle. The external hazard unit holds IF/ID during that cycle, and the dependent instruction is captured on the next edge with WB forwarding.
- **Simultaneous events:**
  - `flush` + `stall`: flush wins.
  - `stall` + `load_use_hazard`: hold (the load stays in EX).
- **Reset mid-stall** clears everything; no state survives.

## Test plan
- **Reset:** assert `reset`=0 mid-cycle -> all outputs 0 immediately. Release; first edge with `id_valid=1`, `id_rs_data=5`, `id_rt_data=7`, alusrc=0 -> `ex_dataa=5`, `ex_datab=7`, `ex_valid=1`.
- **Forward priority:** EX rs=3. Drive `mem_regwrite=1`, `mem_wr_addr=3`, `mem_result=0x11`, `wb_regwrite=1`, `wb_wr_addr=3`, `wb_data=0x22` -> `ex_dataa=0x11`. Drop MEM -> `0x22`. Set both addresses to 0 with rs=0 -> registered value.
- **Load-use:** EX holds lw to $8. ID reads rs=$8 -> `load_use_hazard=1`; next edge `ex_valid=0`, `ex_memread=0`. The following edge captures the instruction; `wb_data=0x1234` to $8 -> `ex_dataa=0x1234`.
- **Stall absorb:** EX rt=$4 with `mem_result=0x55` for $4. Assert `stall` one cycle, MEM then drops -> after the edge `ex_datab=0x55` held and fields unchanged.
- **Flush priority:** `flush=1` with `stall=1` and a valid ID -> next edge `ex_valid=0`, all control bits 0, `ex_dataa=0`.
- **Shift/imm select:** `alusrc1=1`, `shamt=31`; `alusrc2=1`, `imm=0xFFFF8000` -> `ex_dataa=0x1F`, `ex_datab=0xFFFF8000`, and `ex_store_data` still equals forwarded rt.
